// File: rtl/ffe_pkg.sv
// Shared defaults, FSM encoding and reset coefficient for the FFE MAC engine.
package ffe_pkg;

   localparam int DATA_W_DEF    = 12;
   localparam int TAPS_DEF      = 4;
   localparam int FRAC_W_DEF    = 11;
   // Tap-0 reset value: 0.5 in Q1.11, so the reset filter halves the input.
   localparam int COEF_RST_TAP0 = 1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } ffe_state_e;

endpackage

// File: rtl/ffe_round_sat.sv
// Half-up rounding of one full-width tap product, and clipping of the
// accumulator into the output sample range with a clip flag.
module ffe_round_sat #(
   parameter int DATA_W = 12,
   parameter int FRAC_W = 11,
   parameter int ACC_W  = 15
) (
   input  logic signed [2*DATA_W-1:0] i_prod,
   input  logic signed [ACC_W-1:0]    i_acc,
   output logic signed [ACC_W-1:0]    o_term,
   output logic signed [DATA_W-1:0]   o_data,
   output logic                       o_sat
);

   // Half of one output LSB, added before the arithmetic shift (rounds half up).
   localparam logic signed [2*DATA_W:0] RND_HALF =
      {{(2*DATA_W){1'b0}}, 1'b1} << (FRAC_W - 1);

   logic signed [2*DATA_W:0]      w_sum;
   logic        [ACC_W-DATA_W:0]  w_hi;

   assign w_sum  = {i_prod[2*DATA_W-1], i_prod} + RND_HALF;
   assign o_term = ACC_W'(w_sum >>> FRAC_W);
   assign w_hi   = i_acc[ACC_W-1:DATA_W-1];

   // Clip: the value fits when every bit above the output sign bit matches it.
   always_comb begin
      o_data = i_acc[DATA_W-1:0];
      o_sat  = 1'b0;
      if ((&w_hi) || (~|w_hi)) begin
         o_data = i_acc[DATA_W-1:0];
         o_sat  = 1'b0;
      end else if (i_acc[ACC_W-1]) begin
         o_data = {1'b1, {(DATA_W-1){1'b0}}};
         o_sat  = 1'b1;
      end else begin
         o_data = {1'b0, {(DATA_W-1){1'b1}}};
         o_sat  = 1'b1;
      end
   end

endmodule

// File: rtl/ffe_mac_engine.sv
// Feed-forward equalizer: one sample in, TAPS serial multiply-accumulate
// cycles, one saturated sample out with ready/valid on both sides.
// Coefficients are written into a shadow bank and take effect at the
// next sample accept.
module ffe_mac_engine
   import ffe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAPS   = TAPS_DEF,
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic                       ffe_clk,
   input  logic                       rst,
   input  logic                       coef_wr_en,
   input  logic [$clog2(TAPS)-1:0]    coef_wr_addr,
   input  logic signed [DATA_W-1:0]   coef_wr_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [DATA_W-1:0]   in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [DATA_W-1:0]   out_data,
   output logic                       out_sat
);

   localparam int AW    = $clog2(TAPS);
   localparam int ACC_W = DATA_W + AW + 1;

   ffe_state_e                r_state;
   logic [AW-1:0]             r_cnt;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [DATA_W-1:0]  r_x    [TAPS];
   logic signed [DATA_W-1:0]  r_c_sh [TAPS];
   logic signed [DATA_W-1:0]  r_c_act[TAPS];
   logic                      r_in_ready;
   logic                      r_out_valid;
   logic signed [DATA_W-1:0]  r_out_data;
   logic                      r_out_sat;

   logic signed [2*DATA_W-1:0] w_c_ext;
   logic signed [2*DATA_W-1:0] w_x_ext;
   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [ACC_W-1:0]    w_term;
   logic signed [ACC_W-1:0]    w_acc_next;
   logic signed [DATA_W-1:0]   w_sat_data;
   logic                       w_sat;
   logic                       w_accept;

   // Operands sign-extended to product width so the multiply is full precision.
   assign w_c_ext    = {{DATA_W{r_c_act[r_cnt][DATA_W-1]}}, r_c_act[r_cnt]};
   assign w_x_ext    = {{DATA_W{r_x[r_cnt][DATA_W-1]}}, r_x[r_cnt]};
   assign w_prod     = w_c_ext * w_x_ext;
   assign w_acc_next = r_acc + w_term;
   assign w_accept   = in_valid & r_in_ready;

   ffe_round_sat #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_round_sat (
      .i_prod (w_prod),
      .i_acc  (w_acc_next),
      .o_term (w_term),
      .o_data (w_sat_data),
      .o_sat  (w_sat)
   );

   // Control FSM, coefficient banks, delay line, accumulator and output registers.
   always_ff @(posedge ffe_clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            r_x[k]     <= '0;
            r_c_sh[k]  <= (k == 0) ? DATA_W'(COEF_RST_TAP0) : '0;
            r_c_act[k] <= (k == 0) ? DATA_W'(COEF_RST_TAP0) : '0;
         end
      end else begin
         if (coef_wr_en) begin
            r_c_sh[coef_wr_addr] <= coef_wr_data;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_x[0] <= in_data;
                  for (int k = 1; k < TAPS; k++) begin
                     r_x[k] <= r_x[k-1];
                  end
                  // A write landing on the accept edge must reach the active bank too.
                  for (int k = 0; k < TAPS; k++) begin
                     r_c_act[k] <= (coef_wr_en && (coef_wr_addr == AW'(k))) ?
                                   coef_wr_data : r_c_sh[k];
                  end
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_MAC;
               end
            end
            ST_MAC: begin
               r_acc <= w_acc_next;
               if (r_cnt == AW'(TAPS - 1)) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_sat_data;
                  r_out_sat   <= w_sat;
                  r_state     <= ST_OUT;
               end else begin
                  r_cnt <= r_cnt + AW'(1);
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_ffe_mac_engine.sv
// Directed, table-driven bench for ffe_mac_engine (DATA_W=12, TAPS=4, FRAC_W=11).
module tb_ffe_mac_engine;

   logic               ffe_clk = 1'b0;
   logic               rst = 1'b1;
   logic               coef_wr_en = 1'b0;
   logic [1:0]         coef_wr_addr = 2'd0;
   logic signed [11:0] coef_wr_data = 12'sd0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [11:0] in_data = 12'sd0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [11:0] out_data;
   logic               out_sat;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic signed [11:0] din;
      int                 exp_data;
      logic               exp_sat;
   } vec_t;

   vec_t tbl_a[4];
   vec_t tbl_b[8];

   ffe_mac_engine #(
      .DATA_W (12),
      .TAPS   (4),
      .FRAC_W (11)
   ) dut (
      .ffe_clk      (ffe_clk),
      .rst          (rst),
      .coef_wr_en   (coef_wr_en),
      .coef_wr_addr (coef_wr_addr),
      .coef_wr_data (coef_wr_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_sat      (out_sat)
   );

   always #5 ffe_clk = ~ffe_clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge ffe_clk);
      rst = 1'b1;
      @(negedge ffe_clk);
      rst = 1'b0;
   endtask

   task automatic write_coef(input logic [1:0] a, input logic signed [11:0] d);
      @(negedge ffe_clk);
      coef_wr_en   = 1'b1;
      coef_wr_addr = a;
      coef_wr_data = d;
      @(negedge ffe_clk);
      coef_wr_en   = 1'b0;
   endtask

   // wr_mode: 0 = no write, 1 = write on the accept edge, 2 = write during MAC cycle 2
   task automatic run_sample(input string name, input logic signed [11:0] din,
                             input int exp_data, input logic exp_sat,
                             input int wr_mode, input logic [1:0] wa,
                             input logic signed [11:0] wd);
      int n;
      @(negedge ffe_clk);
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge ffe_clk);
         n++;
      end
      chk({name, "_ready"}, int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = din;
      if (wr_mode == 1) begin
         coef_wr_en   = 1'b1;
         coef_wr_addr = wa;
         coef_wr_data = wd;
      end
      @(negedge ffe_clk);
      in_valid   = 1'b0;
      coef_wr_en = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         if (wr_mode == 2 && n == 2) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = wa;
            coef_wr_data = wd;
         end else begin
            coef_wr_en = 1'b0;
         end
         @(negedge ffe_clk);
         n++;
      end
      coef_wr_en = 1'b0;
      chk({name, "_latency"}, n, 5);
      chk({name, "_data"}, int'(out_data), exp_data);
      chk({name, "_sat"}, int'(out_sat), int'(exp_sat));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tbl_a[0] = '{12'sd2047, 1024, 1'b0};
      tbl_a[1] = '{12'sd0,    -512, 1'b0};
      tbl_a[2] = '{12'sd0,     320, 1'b0};
      tbl_a[3] = '{12'sd0,    -128, 1'b0};
      tbl_b[0] = '{12'sd2047,   2046, 1'b0};
      tbl_b[1] = '{12'sd2047,   2047, 1'b1};
      tbl_b[2] = '{12'sd2047,   2047, 1'b1};
      tbl_b[3] = '{12'sd2047,   2047, 1'b1};
      tbl_b[4] = '{-12'sd2048,  2047, 1'b1};
      tbl_b[5] = '{-12'sd2048,    -2, 1'b0};
      tbl_b[6] = '{-12'sd2048, -2048, 1'b1};
      tbl_b[7] = '{-12'sd2048, -2048, 1'b1};

      // Reset state
      repeat (2) @(negedge ffe_clk);
      rst = 1'b0;
      @(negedge ffe_clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_sat", int'(out_sat), 0);

      // Default coefficients halve the input
      run_sample("dflt", 12'sd1000, 500, 1'b0, 0, 2'd0, 12'sd0);

      // Reset in MAC cycle 2 aborts the sample
      @(negedge ffe_clk);
      in_valid = 1'b1;
      in_data  = 12'sd1000;
      @(negedge ffe_clk);
      in_valid = 1'b0;
      @(negedge ffe_clk);
      rst = 1'b1;
      @(negedge ffe_clk);
      rst = 1'b0;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_out_data", int'(out_data), 0);
      run_sample("after_rst", 12'sd1000, 500, 1'b0, 0, 2'd0, 12'sd0);

      // Shadow write mid-flight does not affect the in-flight result
      run_sample("wr_mid", 12'sd1000, 500, 1'b0, 2, 2'd0, 12'sd512);
      run_sample("new_tap0", 12'sd1000, 250, 1'b0, 0, 2'd0, 12'sd0);

      // Back-pressure: output held, no accept until one cycle after release
      @(negedge ffe_clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 12'sd1000;
      @(negedge ffe_clk);
      in_data = 12'sd2000;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge ffe_clk);
         n++;
      end
      chk("hold_valid", int'(out_valid), 1);
      for (int i = 0; i < 10; i++) begin
         chk("hold_data", int'(out_data), 250);
         chk("hold_in_ready", int'(in_ready), 0);
         chk("hold_out_valid", int'(out_valid), 1);
         @(negedge ffe_clk);
      end
      out_ready = 1'b1;
      @(negedge ffe_clk);
      chk("bubble_in_ready", int'(in_ready), 1);
      chk("bubble_out_valid", int'(out_valid), 0);
      @(negedge ffe_clk);
      chk("bubble_accepted", int'(in_ready), 0);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge ffe_clk);
         n++;
      end
      chk("bubble_data", int'(out_data), 500);

      // Impulse response through written coefficients
      do_reset();
      write_coef(2'd0, 12'sd1024);
      write_coef(2'd1, -12'sd512);
      write_coef(2'd2, 12'sd320);
      write_coef(2'd3, -12'sd128);
      for (int i = 0; i < 4; i++) begin
         run_sample($sformatf("impulse%0d", i), tbl_a[i].din, tbl_a[i].exp_data,
                    tbl_a[i].exp_sat, 0, 2'd0, 12'sd0);
      end

      // Saturation at both rails
      for (int i = 0; i < 4; i++) begin
         write_coef(2'(i), 12'sd2047);
      end
      for (int i = 0; i < 8; i++) begin
         run_sample($sformatf("sat%0d", i), tbl_b[i].din, tbl_b[i].exp_data,
                    tbl_b[i].exp_sat, 0, 2'd0, 12'sd0);
      end

      // Write on the accept edge reaches the active bank
      do_reset();
      run_sample("wr_accept", 12'sd1000, -500, 1'b0, 1, 2'd0, -12'sd1024);
      run_sample("wr_accept_kept", 12'sd1000, -500, 1'b0, 0, 2'd0, 12'sd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
